// File: rtl/beam_scan_pkg.sv
// Shared types and width/DOA helpers for the beam_scan delay-and-sum scanner.
package beam_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LATCH   = 3'd1,
        ST_MAC     = 3'd2,
        ST_POWER   = 3'd3,
        ST_COMPARE = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    localparam int CPLX_W = 14;

    // Packed {re,im} pair at the default sample width, matching the RAM/ROM word layout.
    typedef struct packed {
        logic signed [CPLX_W-1:0] re;
        logic signed [CPLX_W-1:0] im;
    } cplx_t;

    function automatic int acc_width(input int samp_w, input int num_mics);
        return 2 * samp_w + 1 + $clog2(num_mics);
    endfunction

    function automatic int pwr_width(input int acc_w);
        return 2 * acc_w + 1;
    endfunction

    function automatic int doa_of(input int doa_start, input int doa_step, input int beam);
        return doa_start + doa_step * beam;
    endfunction

endpackage

// File: rtl/beam_scan_cmul.sv
// Combinational signed complex multiplier; the result is one bit wider than a plain product
// so that the re/im sums never wrap.
module beam_cmul #(
    parameter  int SAMP_W = 14,
    localparam int PROD_W = 2 * SAMP_W + 1
) (
    input  logic signed [SAMP_W-1:0] a_re,
    input  logic signed [SAMP_W-1:0] a_im,
    input  logic signed [SAMP_W-1:0] b_re,
    input  logic signed [SAMP_W-1:0] b_im,
    output logic signed [PROD_W-1:0] p_re,
    output logic signed [PROD_W-1:0] p_im
);

    // Full-precision (a_re + j a_im) * (b_re + j b_im).
    always_comb begin
        p_re = PROD_W'(a_re) * PROD_W'(b_re) - PROD_W'(a_im) * PROD_W'(b_im);
        p_im = PROD_W'(a_re) * PROD_W'(b_im) + PROD_W'(a_im) * PROD_W'(b_re);
    end

endmodule

// File: rtl/beam_scan.sv
// Delay-and-sum beam scanner: snapshots one bin from every mic, scans all steering sets and
// reports the strongest beam. Define BEAM_SCAN_PWR_OUT_EN to expose the per-beam power map.
module beam_scan
    import beam_scan_pkg::*;
#(
    parameter  int NUM_MICS  = 4,
    parameter  int NUM_BEAMS = 37,
    parameter  int BIN_W     = 10,
    parameter  int SAMP_W    = 14,
    parameter  int DOA_START = -90,
    parameter  int DOA_STEP  = 5,
    parameter  int DOA_W     = 8,
    localparam int CA_W      = $clog2(NUM_BEAMS * NUM_MICS),
    localparam int BB_W      = $clog2(NUM_BEAMS),
    localparam int ACC_W     = acc_width(SAMP_W, NUM_MICS),
    localparam int PWR_W     = pwr_width(ACC_W)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic [BIN_W-1:0]               bin,
    output logic [BIN_W-1:0]               spec_rdaddr,
    input  logic [NUM_MICS*2*SAMP_W-1:0]   spec_q,
    output logic [CA_W-1:0]                coef_rdaddr,
    input  logic [2*SAMP_W-1:0]            coef_q,
    output logic                           busy,
    output logic                           done,
    output logic [BB_W-1:0]                best_beam,
    output logic signed [DOA_W-1:0]        doa
`ifdef BEAM_SCAN_PWR_OUT_EN
    ,
    output logic                           pwr_valid,
    output logic [BB_W-1:0]                pwr_beam,
    output logic [PWR_W-1:0]               pwr_data,
    output logic [PWR_W-1:0]               max_pwr
`endif
);

    localparam int MC_W   = $clog2(NUM_MICS + 1);
    localparam int MI_W   = $clog2(NUM_MICS);
    localparam int PROD_W = 2 * SAMP_W + 1;
    localparam int SQ_W   = 2 * ACC_W;

    localparam logic [2:0] IDLE    = ST_IDLE;
    localparam logic [2:0] LATCH   = ST_LATCH;
    localparam logic [2:0] MAC     = ST_MAC;
    localparam logic [2:0] POWER   = ST_POWER;
    localparam logic [2:0] COMPARE = ST_COMPARE;
    localparam logic [2:0] DONE    = ST_DONE;

    logic [2:0]               state_r;
    logic [MC_W-1:0]          cnt_r;
    logic [BB_W-1:0]          beam_r;
    logic [BB_W-1:0]          best_r;
    logic [BIN_W-1:0]         bin_r;
    logic [CA_W-1:0]          coef_addr_r;
    logic signed [SAMP_W-1:0] snap_re_r [NUM_MICS];
    logic signed [SAMP_W-1:0] snap_im_r [NUM_MICS];
    logic signed [ACC_W-1:0]  acc_re_r;
    logic signed [ACC_W-1:0]  acc_im_r;
    logic [PWR_W-1:0]         pwr_r;
    logic [PWR_W-1:0]         max_pwr_r;
    logic                     busy_r;
    logic                     done_r;
    logic [BB_W-1:0]          best_beam_r;
    logic signed [DOA_W-1:0]  doa_r;

    logic [MI_W-1:0]          mic_s;
    logic signed [SAMP_W-1:0] coef_re_s;
    logic signed [SAMP_W-1:0] coef_im_s;
    logic signed [PROD_W-1:0] prod_re_s;
    logic signed [PROD_W-1:0] prod_im_s;
    logic signed [SQ_W-1:0]   re_sq_s;
    logic signed [SQ_W-1:0]   im_sq_s;
    logic [PWR_W-1:0]         pwr_s;
    logic [BB_W-1:0]          best_nxt_s;
    logic [PWR_W-1:0]         max_nxt_s;
    logic                     last_beam_s;

    assign spec_rdaddr = bin_r;
    assign coef_rdaddr = coef_addr_r;
    assign busy        = busy_r;
    assign done        = done_r;
    assign best_beam   = best_beam_r;
    assign doa         = doa_r;

    // Operand select, power and running-maximum decision; ties keep the earlier beam.
    always_comb begin
        mic_s       = MI_W'(cnt_r - MC_W'(1));
        coef_re_s   = coef_q[2*SAMP_W-1:SAMP_W];
        coef_im_s   = coef_q[SAMP_W-1:0];
        re_sq_s     = SQ_W'(acc_re_r) * SQ_W'(acc_re_r);
        im_sq_s     = SQ_W'(acc_im_r) * SQ_W'(acc_im_r);
        pwr_s       = PWR_W'(re_sq_s) + PWR_W'(im_sq_s);
        last_beam_s = (beam_r == BB_W'(NUM_BEAMS - 1));
        if ((beam_r == BB_W'(0)) || (pwr_r > max_pwr_r)) begin
            best_nxt_s = beam_r;
            max_nxt_s  = pwr_r;
        end else begin
            best_nxt_s = best_r;
            max_nxt_s  = max_pwr_r;
        end
    end

    beam_cmul #(.SAMP_W(SAMP_W)) u_cmul (
        .a_re (coef_re_s),
        .a_im (coef_im_s),
        .b_re (snap_re_r[mic_s]),
        .b_im (snap_im_r[mic_s]),
        .p_re (prod_re_s),
        .p_im (prod_im_s)
    );

    // Scan sequencer: latch, per-beam MAC/power/compare, then result publication.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= MC_W'(0);
            beam_r      <= BB_W'(0);
            best_r      <= BB_W'(0);
            bin_r       <= BIN_W'(0);
            coef_addr_r <= CA_W'(0);
            for (int m = 0; m < NUM_MICS; m++) begin
                snap_re_r[m] <= SAMP_W'(0);
                snap_im_r[m] <= SAMP_W'(0);
            end
            acc_re_r    <= ACC_W'(0);
            acc_im_r    <= ACC_W'(0);
            pwr_r       <= PWR_W'(0);
            max_pwr_r   <= PWR_W'(0);
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            best_beam_r <= BB_W'(0);
            doa_r       <= DOA_W'(DOA_START);
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        bin_r       <= bin;
                        busy_r      <= 1'b1;
                        coef_addr_r <= CA_W'(0);
                        cnt_r       <= MC_W'(0);
                        state_r     <= LATCH;
                    end
                end
                LATCH: begin
                    if (cnt_r == MC_W'(0)) begin
                        cnt_r <= MC_W'(1);
                    end else begin
                        for (int m = 0; m < NUM_MICS; m++) begin
                            snap_re_r[m] <= spec_q[m*2*SAMP_W+SAMP_W +: SAMP_W];
                            snap_im_r[m] <= spec_q[m*2*SAMP_W +: SAMP_W];
                        end
                        cnt_r    <= MC_W'(0);
                        beam_r   <= BB_W'(0);
                        acc_re_r <= ACC_W'(0);
                        acc_im_r <= ACC_W'(0);
                        state_r  <= MAC;
                    end
                end
                MAC: begin
                    // ROM data lags its address by one cycle, so cycle k consumes mic k-1.
                    if (cnt_r != MC_W'(0)) begin
                        acc_re_r <= acc_re_r + ACC_W'(prod_re_s);
                        acc_im_r <= acc_im_r + ACC_W'(prod_im_s);
                    end
                    if (cnt_r < MC_W'(NUM_MICS)) begin
                        coef_addr_r <= coef_addr_r + CA_W'(1);
                    end
                    if (cnt_r == MC_W'(NUM_MICS)) begin
                        cnt_r   <= MC_W'(0);
                        state_r <= POWER;
                    end else begin
                        cnt_r <= cnt_r + MC_W'(1);
                    end
                end
                POWER: begin
                    pwr_r   <= pwr_s;
                    state_r <= COMPARE;
                end
                COMPARE: begin
                    max_pwr_r <= max_nxt_s;
                    best_r    <= best_nxt_s;
                    if (last_beam_s) begin
                        done_r      <= 1'b1;
                        best_beam_r <= best_nxt_s;
                        doa_r       <= DOA_W'(doa_of(DOA_START, DOA_STEP, int'(best_nxt_s)));
                        state_r     <= DONE;
                    end else begin
                        beam_r   <= beam_r + BB_W'(1);
                        acc_re_r <= ACC_W'(0);
                        acc_im_r <= ACC_W'(0);
                        state_r  <= MAC;
                    end
                end
                DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

`ifdef BEAM_SCAN_PWR_OUT_EN
    logic             pwr_valid_r;
    logic [BB_W-1:0]  pwr_beam_r;
    logic [PWR_W-1:0] max_pwr_out_r;

    assign pwr_valid = pwr_valid_r;
    assign pwr_beam  = pwr_beam_r;
    assign pwr_data  = pwr_r;
    assign max_pwr   = max_pwr_out_r;

    // Power-map strobe aligned with each COMPARE cycle; final maximum held with best_beam.
    always_ff @(posedge clk) begin
        if (reset) begin
            pwr_valid_r   <= 1'b0;
            pwr_beam_r    <= BB_W'(0);
            max_pwr_out_r <= PWR_W'(0);
        end else begin
            pwr_valid_r <= (state_r == POWER);
            if (state_r == POWER) begin
                pwr_beam_r <= beam_r;
            end
            if ((state_r == COMPARE) && last_beam_s) begin
                max_pwr_out_r <= max_nxt_s;
            end
        end
    end
`endif

endmodule

// File: tb/tb_beam_scan.sv
// Self-checking bench for beam_scan: directed scenarios plus random frames against a
// complex-arithmetic reference model.
module tb_beam_scan;
    import beam_scan_pkg::*;

    localparam int NUM_MICS  = 4;
    localparam int NUM_BEAMS = 37;
    localparam int BIN_W     = 10;
    localparam int SAMP_W    = 14;
    localparam int DOA_W     = 8;
    localparam int NCOEF     = NUM_BEAMS * NUM_MICS;
    localparam int LAT       = 261;   // edges after the accepting edge: 2 + 37*7 (cycle 262)

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         start;
    logic [BIN_W-1:0]             bin;
    logic [BIN_W-1:0]             spec_rdaddr;
    logic [NUM_MICS*2*SAMP_W-1:0] spec_q = '0;
    logic [7:0]                   coef_rdaddr;
    logic [2*SAMP_W-1:0]          coef_q = '0;
    logic                         busy;
    logic                         done;
    logic [5:0]                   best_beam;
    logic signed [DOA_W-1:0]      doa;

    logic [NUM_MICS*2*SAMP_W-1:0] spec_mem [0:1023];
    logic [2*SAMP_W-1:0]          coef_mem [0:NCOEF-1];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    logic   m_busy;
    logic   m_done;
    int     m_cnt;
    int     m_best;
    int     pend_best;
    longint pend_pwr;

    always #5 clk = ~clk;

    beam_scan dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .bin         (bin),
        .spec_rdaddr (spec_rdaddr),
        .spec_q      (spec_q),
        .coef_rdaddr (coef_rdaddr),
        .coef_q      (coef_q),
        .busy        (busy),
        .done        (done),
        .best_beam   (best_beam),
        .doa         (doa)
    );

    always @(posedge clk) spec_q <= spec_mem[spec_rdaddr];
    always @(posedge clk) coef_q <= (int'(coef_rdaddr) < NCOEF) ? coef_mem[coef_rdaddr] : 28'd0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // |sum over mics of coef*spec|^2 for one beam, straight from the complex definition.
    function automatic longint beam_power(input int b, input logic [BIN_W-1:0] a);
        logic [NUM_MICS*2*SAMP_W-1:0] w;
        logic [2*SAMP_W-1:0] c;
        longint sr, si, cr, ci, tre, tim;
        w = spec_mem[a];
        tre = 0;
        tim = 0;
        for (int m = 0; m < NUM_MICS; m++) begin
            sr = longint'($signed(w[m*28+14 +: 14]));
            si = longint'($signed(w[m*28 +: 14]));
            c  = coef_mem[b*NUM_MICS+m];
            cr = longint'($signed(c[27:14]));
            ci = longint'($signed(c[13:0]));
            tre += cr * sr - ci * si;
            tim += cr * si + ci * sr;
        end
        return tre * tre + tim * tim;
    endfunction

    function automatic int best_of(input logic [BIN_W-1:0] a);
        int bi;
        longint bp, p;
        bi = 0;
        bp = beam_power(0, a);
        for (int b = 1; b < NUM_BEAMS; b++) begin
            p = beam_power(b, a);
            if (p > bp) begin
                bp = p;
                bi = b;
            end
        end
        return bi;
    endfunction

    // Reference model: one scan takes LAT edges, ignores start while busy, results at done.
    always @(posedge clk) begin
        if (reset) begin
            m_busy <= 1'b0;
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_best <= 0;
        end else begin
            m_done <= 1'b0;
            if (m_busy) begin
                m_cnt <= m_cnt + 1;
                if (m_cnt + 1 == LAT) begin
                    m_done <= 1'b1;
                    m_best <= pend_best;
                end
                if (m_cnt + 1 == LAT + 1) m_busy <= 1'b0;
            end else if (start) begin
                m_busy    <= 1'b1;
                m_cnt     <= 0;
                pend_best <= best_of(bin);
                pend_pwr  <= beam_power(best_of(bin), bin);
            end
        end
    end

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", longint'(busy), longint'(m_busy));
            check("done", longint'(done), longint'(m_done));
            check("best_beam", longint'(best_beam), longint'(m_best));
            check("doa", longint'(doa), longint'(-90 + 5 * m_best));
        end
    end

    task automatic set_spec(input int a, input int re, input int im);
        logic [NUM_MICS*2*SAMP_W-1:0] w;
        cplx_t c;
        c.re = 14'(re);
        c.im = 14'(im);
        for (int m = 0; m < NUM_MICS; m++) w[m*28 +: 28] = c;
        spec_mem[a] = w;
    endtask

    task automatic set_beam(input int b, input int re, input int im);
        cplx_t c;
        c.re = 14'(re);
        c.im = 14'(im);
        for (int m = 0; m < NUM_MICS; m++) coef_mem[b*NUM_MICS+m] = c;
    endtask

    task automatic clear_coefs();
        for (int i = 0; i < NCOEF; i++) coef_mem[i] = 28'd0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (n < 400) begin
            @(negedge clk);
            n++;
            if (done === 1'b1) break;
        end
        check("done_seen", longint'(done === 1'b1), 64'd1);
    endtask

    task automatic run_scan(input logic [BIN_W-1:0] b, output int lat);
        @(negedge clk);
        bin   = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
    endtask

    initial begin
        int lat;
        int nd;
        logic [127:0] r;
        reset = 1'b1;
        start = 1'b0;
        bin   = 10'd0;
        for (int i = 0; i < 1024; i++) spec_mem[i] = '0;
        clear_coefs();
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_busy", longint'(busy), 64'd0);
        check("rst_done", longint'(done), 64'd0);
        check("rst_best", longint'(best_beam), 64'd0);
        check("rst_doa", longint'(doa), -64'sd90);
        reset = 1'b0;

        // Only beam 7 steers energy: power 400^2 there, zero elsewhere.
        set_spec(5, 100, 0);
        set_beam(7, 1, 0);
        run_scan(10'd5, lat);
        check("t1_latency", lat, 64'd261);
        check("t1_best", longint'(best_beam), 64'd7);
        check("t1_doa", longint'(doa), -64'sd55);
        check("t1_model_best", m_best, 64'd7);

        // Beams 3 and 12 tie at 160000 (different phase), beam 8 is 10000.
        clear_coefs();
        set_beam(3, 1, 0);
        set_beam(12, 0, 1);
        coef_mem[8*NUM_MICS] = {14'sd1, 14'sd0};
        run_scan(10'd5, lat);
        check("tie_best", longint'(best_beam), 64'd3);
        check("tie_doa", longint'(doa), -64'sd75);

        // Extremes: each product is j*2^27, four mics give j*2^29, power 2^58.
        set_spec(7, -8192, -8192);
        for (int b = 0; b < NUM_BEAMS; b++) set_beam(b, -8192, -8192);
        run_scan(10'd7, lat);
        check("ext_best", longint'(best_beam), 64'd0);
        check("ext_model_pwr", pend_pwr, 64'd288230376151711744);
        check("ext_max_pwr", longint'(dut.max_pwr_r), 64'd288230376151711744);

        // Start pulse mid-scan is ignored; exactly one done follows.
        clear_coefs();
        set_beam(7, 1, 0);
        @(negedge clk);
        bin   = 10'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (49) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        nd = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (done === 1'b1) nd++;
        end
        check("ign_done_count", nd, 64'd1);
        check("ign_best", longint'(best_beam), 64'd7);

        // Start held through the DONE cycle is taken only in the following IDLE cycle.
        run_scan(10'd5, lat);
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
        check("restart_latency", lat, 64'd261);

        // Reset seen at edge 100 of a scan returns everything to reset values.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (99) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", longint'(busy), 64'd0);
        check("mid_rst_doa", longint'(doa), -64'sd90);
        check("mid_rst_best", longint'(best_beam), 64'd0);
        reset = 1'b0;
        run_scan(10'd5, lat);
        check("post_rst_latency", lat, 64'd261);
        check("post_rst_doa", longint'(doa), -64'sd55);

        // Bin and RAM contents change after the snapshot; the result must not.
        @(negedge clk);
        bin   = 10'd5;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        bin = 10'd9;
        set_spec(5, 0, 0);
        wait_done(lat);
        check("snap_best", longint'(best_beam), 64'd7);
        check("snap_doa", longint'(doa), -64'sd55);

        // Random frames against the model.
        for (int f = 0; f < 200; f++) begin
            bin = 10'($urandom_range(0, 1023));
            r = {$urandom(), $urandom(), $urandom(), $urandom()};
            spec_mem[bin] = r[111:0];
            for (int i = 0; i < NCOEF; i++) coef_mem[i] = 28'($urandom());
            run_scan(bin, lat);
            check("rand_latency", lat, 64'd261);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
